// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port 256x8 synchronous memory, with lock and lock timeout.
// Optional round-robin tie-break via `define MEM_ARB_RR_EN (otherwise port 0 wins IDLE ties).
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_i,
  input  logic [DATA_W-1:0] mem_d_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             starve_q, starve_d;
  logic             starve_port_q, starve_port_d;
  logic             rv0_q, rv1_q;
  logic             tie_pick;
  logic             starved_req;

`ifdef MEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  always_comb begin
    rr_last_d = rr_last_q;
    if (m1_gnt)      rr_last_d = 1'b1;
    else if (m0_gnt) rr_last_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
`endif

  // A pending starve overrides the normal tie-break so the released port is served first
  always_comb begin
`ifdef MEM_ARB_RR_EN
    tie_pick = ~rr_last_q;
`else
    tie_pick = 1'b0;
`endif
    if (starve_q) tie_pick = starve_port_q;
  end

  assign starved_req = starve_port_q ? m1_req : m0_req;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        LOCK0:   m0_gnt = m0_req;
        LOCK1:   m1_gnt = m1_req;
        default: begin
          if (m0_req && m1_req) begin
            m0_gnt = ~tie_pick;
            m1_gnt = tie_pick;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d_i  = '0;
    if (m0_gnt) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_d_i  = m0_wdata;
    end else if (m1_gnt) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_d_i  = m1_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    starve_d      = starve_q;
    starve_port_d = starve_port_q;
    if ((m0_gnt && !starve_port_q) || (m1_gnt && starve_port_q)) starve_d = 1'b0;
    case (state_q)
      LOCK0: begin
        if (!m0_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_W'(LOCK_MAX)) begin
          state_d       = IDLE;
          lock_cnt_d    = '0;
          starve_d      = 1'b1;
          starve_port_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      LOCK1: begin
        if (!m1_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_W'(LOCK_MAX)) begin
          state_d       = IDLE;
          lock_cnt_d    = '0;
          starve_d      = 1'b1;
          starve_port_d = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        lock_cnt_d = '0;
        if (starve_q && !starved_req) starve_d = 1'b0;
        if (m0_gnt && m0_lock) begin
          state_d    = LOCK0;
          lock_cnt_d = CNT_W'(1);
        end else if (m1_gnt && m1_lock) begin
          state_d    = LOCK1;
          lock_cnt_d = CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lock_cnt_q    <= '0;
      starve_q      <= 1'b0;
      starve_port_q <= 1'b0;
      rv0_q         <= 1'b0;
      rv1_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      starve_q      <= starve_d;
      starve_port_q <= starve_port_d;
      rv0_q         <= m0_gnt & ~m0_we;
      rv1_q         <= m1_gnt & ~m1_we;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = mem_d_o;
  assign m1_rdata  = mem_d_o;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port 256x8 synchronous memory. It shares the memory's one `we`/`addr`/`d_i`/`d_o` port between two requesters: port 0 (CPU fetch/execute) and port 1 (program loader/debug). It issues at most one access per cycle and returns read data with the memory's one-cycle latency. It also supports a lock for atomic multi-access sequences, bounded by a timeout.

## Interface
Parameters:
- `ADDR_W`, 8: address width; must match memory.
- `DATA_W`, 8: data width; must match memory.
- `LOCK_MAX`, 16: maximum consecutive cycles a port may hold lock (1..255).

Ports (n = 0, 1):
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mn_req`  in  1  access request; held until `mn_gnt`.
- `mn_lock`  in  1  request/hold exclusive ownership.
- `mn_we`  in  1  1 = write, 0 = read.
- `mn_addr`  in  ADDR_W  access address.
- `mn_wdata`  in  DATA_W  write data.
- `mn_gnt`  out  1  combinational; access accepted this cycle.
- `mn_rvalid`  out  1  registered; read data valid this cycle.
- `mn_rdata`  out  DATA_W  equals `mem_d_o`; meaningful only while `mn_rvalid`=1.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_d_i`  out  DATA_W  to memory `d_i`.
- `mem_d_o`  in  DATA_W  from memory `d_o`.

## Operation
- States:
  - IDLE: no owner.
  - LOCK0: port 0 owns the memory.
  - LOCK1: port 1 owns the memory.
- Registers:
  - `state`.
  - `rr_last`: last-granted port, 1 bit.
  - `lock_cnt`: clog2(LOCK_MAX+1) bits.
  - `rv0`, `rv1`.
  - `starve`: 1 bit.
- IDLE arbitration:
  - Exactly one `req` high: grant that port.
  - Both high: grant the port other than `rr_last`.
  - If `starve`=1: the port not forced out wins regardless of `rr_last`.
- Mux: `mem_we`/`mem_addr`/`mem_d_i` follow the granted port. With no grant: `mem_we`=0, `mem_addr`=0, `mem_d_i`=0.
- On grant:
  - `rr_last` <= granted port.
  - If the granted port's `lock`=1 and state is IDLE: next state LOCKn, `lock_cnt` <= 1.
- In LOCKn:
  - Only port n may be granted; the other port's `gnt`=0 even if requesting.
  - `lock_cnt` increments every cycle.
  - Exit to IDLE at the edge where `mn_lock`=0 (that cycle still grants n if requested).
  - Exit to IDLE at the edge where `lock_cnt`=LOCK_MAX (forced release). Forced release sets `starve`=1 for the other port. `starve` clears on that port's next grant or when it is not requesting in IDLE.
- Read return: `rvn` <= `mn_gnt & ~mn_we`. Writes produce no `rvalid`.
- A write-then-read of the same address returns the new data, because the memory is write-first.

## Timing
- Grant: same cycle as request when eligible, zero added latency.
- Read latency: `mn_rvalid`=1 exactly one cycle after the `mn_gnt` cycle.
- Throughput: one access per cycle total. Back-to-back grants to the same port are allowed.
- Reset values (asserted anytime, including mid-lock or with a read in flight):
  - state=IDLE, `rr_last`=1 (port 0 wins the first tie), `lock_cnt`=0, `starve`=0.
  - `m0_rvalid`=`m1_rvalid`=0; an in-flight read is dropped.
  - All `gnt`=0 and `mem_we`=0 while `rst`=1.
- Simultaneous events:
  - `lock` falling and the other port requesting in the same cycle: the other port is granted the following cycle.
  - Lock requested by both in IDLE: only the granted port locks.
- Changing `mn_addr`/`mn_we`/`mn_wdata` while `mn_req`=1 and `gnt`=0 is allowed; the values sampled in the `gnt` cycle are used.

## Configuration
- `MEM_ARB_RR_EN`, defined: round-robin tie-break via `rr_last` as described above.
- Not defined: fixed priority, port 0 always wins IDLE ties. `rr_last` is not implemented. The lock, timeout and `starve` mechanisms are unchanged, so port 1 is still guaranteed service after a forced release.

## Test plan
- Reset then port 0 only: m0 writes 0xA5 to addr 0x10, then reads 0x10. Required: `m0_gnt` in each request cycle; `m0_rvalid`=1 one cycle after the read grant; `m0_rdata`=0xA5.
- Tie, RR enabled: both ports request reads of 0x00/0x01 continuously. Required: grants alternate 0,1,0,1; each `rvalid` lands on the correct port with the correct data.
- Tie, RR disabled: same stimulus as the previous scenario. Required: only m0 is granted while it requests; m1 is granted on the first cycle m0 drops `req`.
- Lock: m0 requests with lock=1 for 3 accesses while m1 requests continuously. Required: m1 `gnt`=0 throughout; m1 is granted the cycle after m0 lock falls.
- Timeout: LOCK_MAX=4; m0 holds lock and `req` indefinitely with m1 requesting. Required: forced release after 4 cycles; m1 granted next; m0 may then re-arbitrate.
- Reset mid-read: assert `rst` in the cycle after a m1 read grant. Required: `m1_rvalid`=0 immediately; state=IDLE; first post-reset tie goes to m0.
